dot_reducer: RTL and testbench

- Sequential result collector on the output side of the combinational dot-product array.
- Accepts the array's two partial sums once per tile over a valid/ready handshake and adds them.
- Accumulates the sums over a run of len tiles, then presents one signed result with valid/ready backpressure and a sticky overflow flag.

---
 rtl/dot_reducer_if.sv | 28 ++
 rtl/dot_reducer.sv | 95 +++++++++
 tb/tb_dot_reducer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dot_reducer_if.sv
// Handshake bundle between the dot-product array, the result collector and its consumer.
// The array side drives the partial-sum channel; the consumer drives res_ready.
interface dot_reducer_if #(
    parameter int unsigned PSUM_W = 20,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LEN_W  = 16
);
    logic signed [PSUM_W-1:0] psum_0;
    logic signed [PSUM_W-1:0] psum_1;
    logic                     psum_valid;
    logic                     psum_ready;
    logic        [LEN_W-1:0]  len;
    logic signed [ACC_W-1:0]  res;
    logic                     res_valid;
    logic                     res_ready;
    logic                     res_ovf;
    logic                     busy;

    modport master (
        output psum_0, psum_1, psum_valid, len, res_ready,
        input  psum_ready, res, res_valid, res_ovf, busy
    );

    modport slave (
        input  psum_0, psum_1, psum_valid, len, res_ready,
        output psum_ready, res, res_valid, res_ovf, busy
    );
endinterface

// File: rtl/dot_reducer.sv
// Collects partial-sum pairs from the dot-product array and accumulates them over a run
// of len tiles, then offers one signed result with backpressure and a sticky overflow flag.
module dot_reducer #(
    parameter int unsigned IN_SIZE_0 = 4,
    parameter int unsigned IN_SIZE_1 = 8,
    parameter int unsigned PSUM_W    = IN_SIZE_0 + IN_SIZE_1 + 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned LEN_W     = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    dot_reducer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [LEN_W-1:0] cnt_q, cnt_d;
    logic        [LEN_W-1:0] len_q, len_d;
    logic                    ovf_q, ovf_d;

    logic signed [PSUM_W:0]  pair_sum;
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    add_ovf;
    logic                    beat;

    // One extra bit keeps the pair sum exact before widening to the accumulator.
    assign pair_sum = {bus.psum_0[PSUM_W-1], bus.psum_0} + {bus.psum_1[PSUM_W-1], bus.psum_1};
    assign beat_sum = ACC_W'(pair_sum);
    assign acc_sum  = acc_q + beat_sum;
    assign add_ovf  = (acc_q[ACC_W-1] == beat_sum[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    assign bus.psum_ready = (state_q != StOutput) && !rst_i;
    assign beat           = bus.psum_valid && bus.psum_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (beat) begin
                    len_d   = (bus.len == '0) ? LEN_W'(1) : bus.len;
                    acc_d   = beat_sum;
                    cnt_d   = LEN_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (len_d == LEN_W'(1)) ? StOutput : StAccum;
                end
            end
            StAccum: begin
                if (beat) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + LEN_W'(1);
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_d == len_q) begin
                        state_d = StOutput;
                    end
                end
            end
            StOutput: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // The accumulator only moves on accepted beats, so it doubles as the held result.
    assign bus.res       = acc_q;
    assign bus.res_valid = (state_q == StOutput);
    assign bus.res_ovf   = ovf_q && (state_q == StOutput);
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_dot_reducer.sv
// Bench for dot_reducer: a 32-bit and a 22-bit accumulator instance share one stimulus
// stream and are compared against a transaction-level model of runs and results.
module tb_dot_reducer;
    localparam int unsigned PW = 20;
    localparam int unsigned LW = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic signed [PW-1:0] p0 = '0;
    logic signed [PW-1:0] p1 = '0;
    logic                 pv = 1'b0;
    logic        [LW-1:0] len = '0;
    logic                 rr = 1'b0;

    dot_reducer_if #(.PSUM_W(PW), .ACC_W(32), .LEN_W(LW)) a_if ();
    dot_reducer_if #(.PSUM_W(PW), .ACC_W(22), .LEN_W(LW)) b_if ();

    assign a_if.psum_0 = p0;
    assign a_if.psum_1 = p1;
    assign a_if.psum_valid = pv;
    assign a_if.len = len;
    assign a_if.res_ready = rr;
    assign b_if.psum_0 = p0;
    assign b_if.psum_1 = p1;
    assign b_if.psum_valid = pv;
    assign b_if.len = len;
    assign b_if.res_ready = rr;

    dot_reducer u_dut32 (.clk_i(clk_i), .rst_i(rst_i), .bus(a_if));
    dot_reducer #(.ACC_W(22)) u_dut22 (.clk_i(clk_i), .rst_i(rst_i), .bus(b_if));

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(string tag, longint got, longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Model: beats of the current (or most recent) run, its length, and run status.
    int m_run[$];
    int m_len = 0;
    bit m_active = 1'b0;
    bit m_pending = 1'b0;

    function automatic longint wrap(longint v, int w);
        longint m = longint'(1) << w;
        longint r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // Running sum with wraparound; flags any step whose exact sum leaves the signed range.
    function automatic void run_result(int w, output longint r, output bit o);
        longint lim = longint'(1) << (w - 1);
        longint e;
        r = 0;
        o = 1'b0;
        foreach (m_run[i]) begin
            e = r + m_run[i];
            if (e >= lim || e < -lim) o = 1'b1;
            r = wrap(e, w);
        end
    endfunction

    task automatic check_outputs();
        longint r32, r22;
        bit o32, o22;
        run_result(32, r32, o32);
        run_result(22, r22, o22);
        check("psum_ready32", a_if.psum_ready, !m_pending);
        check("psum_ready22", b_if.psum_ready, !m_pending);
        check("res_valid32", a_if.res_valid, m_pending);
        check("res_valid22", b_if.res_valid, m_pending);
        check("busy32", a_if.busy, m_active);
        check("res32", longint'($signed(a_if.res)), r32);
        check("res22", longint'($signed(b_if.res)), r22);
        check("ovf32", a_if.res_ovf, m_pending && o32);
        check("ovf22", b_if.res_ovf, m_pending && o22);
    endtask

    // One clock: drive, check the state left by the previous edge, then advance the model.
    task automatic cycle(bit v, int a, int b, int l, bit r);
        bit beat, hs;
        int sum;
        pv = v;
        p0 = a[PW-1:0];
        p1 = b[PW-1:0];
        len = l[LW-1:0];
        rr = r;
        @(negedge clk_i);
        check_outputs();
        beat = v && !m_pending;
        hs = m_pending && r;
        sum = int'(p0) + int'(p1);
        @(posedge clk_i);
        if (beat) begin
            if (!m_active) begin
                m_run.delete();
                m_len = (l == 0) ? 1 : l;
                m_active = 1'b1;
            end
            m_run.push_back(sum);
            if (m_run.size() == m_len) m_pending = 1'b1;
        end else if (hs) begin
            m_pending = 1'b0;
            m_active = 1'b0;
        end
        #1;
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_ready"}, a_if.psum_ready, 0);
        check({tag, "_valid"}, a_if.res_valid, 0);
        check({tag, "_busy"}, a_if.busy, 0);
        check({tag, "_res32"}, longint'($signed(a_if.res)), 0);
        check({tag, "_res22"}, longint'($signed(b_if.res)), 0);
        check({tag, "_ovf"}, a_if.res_ovf, 0);
    endtask

    task automatic pulse_reset();
        pv = 1'b0;
        rr = 1'b0;
        #2 rst_i = 1'b1;
        #1 check_reset_values("rst_async");
        m_run.delete();
        m_active = 1'b0;
        m_pending = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    function automatic int rnd_psum();
        int lim = 1 << (PW - 1);
        unique case ($urandom_range(0, 5))
            0: return lim - 1;
            1: return -lim;
            default: return int'($urandom_range(0, (1 << PW) - 1)) - lim;
        endcase
    endfunction

    initial begin
        #3 check_reset_values("rst_init");
        #9 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single tile.
        cycle(1, 100, -30, 1, 0);
        check("t1_res", longint'($signed(a_if.res)), 70);
        check("t1_valid", a_if.res_valid, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("t1_busy_after", a_if.busy, 0);
        cycle(0, 0, 0, 0, 0);

        // len 0 is treated as 1.
        cycle(1, 5, 6, 0, 1);
        check("t2_res", longint'($signed(a_if.res)), 11);
        cycle(0, 0, 0, 0, 1);

        // Four back-to-back beats; len change mid-run ignored.
        cycle(1, 1, 2, 4, 0);
        cycle(1, -3, -4, 2, 0);
        cycle(1, 10, 0, 2, 0);
        cycle(1, -1, -1, 2, 0);
        check("t3_res", longint'($signed(a_if.res)), 4);
        for (int i = 0; i < 5; i++) cycle(1, 9, 9, 1, 0);
        check("t3_held", longint'($signed(a_if.res)), 4);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Overflow on the 22-bit instance, then a clean run.
        for (int i = 0; i < 3; i++) cycle(1, 524287, 524287, 3, 0);
        check("t4_res22", longint'($signed(b_if.res)), -1048582);
        check("t4_ovf22", b_if.res_ovf, 1);
        check("t4_res32", longint'($signed(a_if.res)), 3145722);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 1, 1, 1, 0);
        check("t5_res22", longint'($signed(b_if.res)), 2);
        check("t5_ovf22", b_if.res_ovf, 0);
        cycle(0, 0, 0, 0, 1);

        // Reset mid-run.
        cycle(1, 7, 7, 4, 0);
        cycle(1, 7, 7, 4, 0);
        pulse_reset();
        cycle(1, 2, 3, 1, 0);
        check("t6_res", longint'($signed(a_if.res)), 5);
        cycle(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) pulse_reset();
            else cycle($urandom_range(0, 9) < 7, rnd_psum(), rnd_psum(),
                       int'($urandom_range(0, 5)), $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
